// File: rtl/nan_result_gen.sv
// nan_result_gen
//   Output-side companion to the FP8 NaN classifier. It takes an arithmetic
//   unit's operands, its nominal result and its invalid-operation indication,
//   and produces the final FP8 result. The block handles NaN propagation with
//   priority, sNaN quieting, default-NaN generation and the invalid flags.
//   It is built as a 2-stage valid/ready pipeline:
//     stage 1 registers the inputs together with their NaN class bits,
//     stage 2 registers the selected result and its flags.
//
//   NaN encodings (the FPU_PACK _NAN_0.._NAN_5 set):
//     quiet     : 8'h7E, 8'h7F, 8'hFF  (bit[QUIET_BIT] = 1)
//     signaling : 8'h7C, 8'h7D, 8'hFD  (bit[QUIET_BIT] = 0)
//   Setting QUIET_BIT on a signaling encoding yields its quiet partner.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  upstream handshake
//   op_a, op_b      FP8 operands
//   op_res          nominal arithmetic result
//   inv_op          the unit flags an invalid operation
//   out_valid/ready downstream handshake
//   fp8_out         resolved FP8 result
//   is_nan_out      fp8_out is a NaN
//   flag_invalid    this result raised invalid
//   sticky_invalid  OR of flag_invalid over accepted outputs since last clear
//   clr_sticky      clear sticky_invalid
module nan_result_gen #(
  parameter logic [7:0] DEFAULT_NAN = 8'h7F,
  parameter int         QUIET_BIT   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [7:0] op_res,
  input  logic       inv_op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] fp8_out,
  output logic       is_nan_out,
  output logic       flag_invalid,
  output logic       sticky_invalid,
  input  logic       clr_sticky
);

  localparam logic [7:0] NAN_0 = 8'h7C;
  localparam logic [7:0] NAN_1 = 8'h7D;
  localparam logic [7:0] NAN_2 = 8'h7E;
  localparam logic [7:0] NAN_3 = 8'h7F;
  localparam logic [7:0] NAN_4 = 8'hFD;
  localparam logic [7:0] NAN_5 = 8'hFF;

  // Only the six listed encodings are NaNs; any other pattern is passed
  // through as an ordinary number.
  function automatic logic is_nan(input logic [7:0] v);
    return (v == NAN_0) || (v == NAN_1) || (v == NAN_2) ||
           (v == NAN_3) || (v == NAN_4) || (v == NAN_5);
  endfunction

  function automatic logic [7:0] quieten(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    r[QUIET_BIT] = 1'b1;
    return r;
  endfunction

  // Stage 1 state
  logic       s1_valid;
  logic [7:0] s1_a;
  logic [7:0] s1_b;
  logic [7:0] s1_res;
  logic       s1_inv;
  logic       s1_a_sn;
  logic       s1_b_sn;
  logic       s1_a_qn;
  logic       s1_b_qn;

  // Stage 2 loads whenever it is empty or its content leaves this cycle.
  // Stage 1 can then always move on, so in_ready follows out_ready
  // combinationally and a full pipeline streams without a bubble.
  logic s2_load;
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_res   <= '0;
      s1_inv   <= 1'b0;
      s1_a_sn  <= 1'b0;
      s1_b_sn  <= 1'b0;
      s1_a_qn  <= 1'b0;
      s1_b_qn  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a    <= op_a;
        s1_b    <= op_b;
        s1_res  <= op_res;
        s1_inv  <= inv_op;
        s1_a_sn <= is_nan(op_a) && !op_a[QUIET_BIT];
        s1_b_sn <= is_nan(op_b) && !op_b[QUIET_BIT];
        s1_a_qn <= is_nan(op_a) &&  op_a[QUIET_BIT];
        s1_b_qn <= is_nan(op_b) &&  op_b[QUIET_BIT];
      end
    end
  end

  // Result selection: signaling NaNs beat quiet NaNs, operand A beats B,
  // and a quiet NaN operand beats the default NaN of an invalid operation.
  logic [7:0] sel_res;
  logic       sel_nan;
  logic       sel_flag;

  always_comb begin
    sel_res  = s1_res;
    sel_nan  = is_nan(s1_res);
    sel_flag = 1'b0;
    if (s1_a_sn) begin
      sel_res  = quieten(s1_a);
      sel_nan  = 1'b1;
      sel_flag = 1'b1;
    end else if (s1_b_sn) begin
      sel_res  = quieten(s1_b);
      sel_nan  = 1'b1;
      sel_flag = 1'b1;
    end else if (s1_a_qn) begin
      sel_res  = s1_a;
      sel_nan  = 1'b1;
      sel_flag = s1_inv;
    end else if (s1_b_qn) begin
      sel_res  = s1_b;
      sel_nan  = 1'b1;
      sel_flag = s1_inv;
    end else if (s1_inv) begin
      sel_res  = DEFAULT_NAN;
      sel_nan  = 1'b1;
      sel_flag = 1'b1;
    end
  end

  // Stage 2: outputs only change when the stage loads, so they stay put
  // while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      fp8_out      <= '0;
      is_nan_out   <= 1'b0;
      flag_invalid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        fp8_out      <= sel_res;
        is_nan_out   <= sel_nan;
        flag_invalid <= sel_flag;
      end
    end
  end

  // Sticky flag: only a completed output handshake can set it; a set in
  // the same cycle as a clear takes precedence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_invalid <= 1'b0;
    end else if (out_valid && out_ready && flag_invalid) begin
      sticky_invalid <= 1'b1;
    end else if (clr_sticky) begin
      sticky_invalid <= 1'b0;
    end
  end

endmodule

// File: doc/nan_result_gen.md
Name: nan_result_gen

Overview:
- Output-side companion to the FP8 NaN classifier. It takes an arithmetic unit's operands, its nominal result and its invalid-operation indication, and produces the final IEEE-style FP8 result.
- NaN propagation with priority, sNaN quieting, default-NaN generation on invalid operations, and per-result plus sticky invalid flags.
- Sits between the FPU datapath and the writeback stage, as a 2-stage valid/ready pipeline.

Parameters:
- DEFAULT_NAN, 8'h7F: canonical quiet NaN emitted on an invalid operation with no NaN operand. Must be one of the FPU_PACK NaN constants with bit[1]=1.
- QUIET_BIT, 1: bit index set to quiet an sNaN. It matches the classifier's qs_NaN bit.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream has a result to resolve
- in_ready  out  1  block accepts input this cycle
- op_a  in  8  FP8 operand A
- op_b  in  8  FP8 operand B
- op_res  in  8  nominal arithmetic result
- inv_op  in  1  unit flags an invalid operation (e.g. inf-inf, 0*inf)
- out_valid  out  1  fp8_out is valid
- out_ready  in  1  downstream accepts output
- fp8_out  out  8  resolved FP8 result
- is_nan_out  out  1  fp8_out is a NaN
- flag_invalid  out  1  this result raised invalid
- sticky_invalid  out  1  OR of flag_invalid over all accepted outputs since the last clear
- clr_sticky  in  1  clear sticky_invalid

Behaviour:
Reset:
- Reset is asynchronous: all valids, fp8_out, is_nan_out, flag_invalid and sticky_invalid go to 0.
- in_ready is 1 the first cycle after reset release.
- Reset asserted mid-operation drops all in-flight data; no partial output is emitted.

Classification:
- NaN means equal to one of `_NAN_0..`_NAN_5.
- qNaN means NaN with bit[QUIET_BIT]=1; sNaN means NaN with bit[QUIET_BIT]=0.
- Non-NaN values are never reinterpreted.

Stage 1 (capture and classify):
- On in_valid && in_ready, register the inputs plus 4 class bits: a_sn, b_sn, a_qn, b_qn.

Stage 2 (select), priority highest first:
- a_sn: op_a with QUIET_BIT forced to 1; flag_invalid=1.
- b_sn: op_b quieted; flag_invalid=1.
- a_qn: op_a unchanged; flag=inv_op.
- b_qn: op_b unchanged; flag=inv_op.
- inv_op: DEFAULT_NAN; flag=1.
- otherwise: op_res unchanged; flag=0.
- is_nan_out=1 for the first five cases, and for the last case iff op_res is a NaN.

Handshake:
- Latency is 2 cycles from input accept to out_valid when there is no stall. Throughput is 1 per cycle.
- Stage 2 loads when it is empty or out_ready=1. Stage 1 advances when stage 2 loads.
- in_ready = !s1_valid || stage-1 advance (combinational from out_ready; no bubble).
- While out_valid && !out_ready, all outputs hold stable. Inputs are not accepted once both stages are full.
- out_valid drops after the output handshake if no new data is behind it.

Sticky flag:
- On an output handshake (out_valid && out_ready), sticky_invalid |= flag_invalid.
- clr_sticky clears sticky_invalid the next cycle.
- clr_sticky coincident with a handshake carrying flag_invalid=1: set wins, sticky ends at 1.
- No handshake means no sticky update, even if flag_invalid=1 is held during a stall.

Test Plan:
- Reset release, then op_a=8'h3C, op_b=8'h40, op_res=8'h44, inv_op=0, out_ready=1 -> out_valid two cycles after accept, fp8_out=8'h44, is_nan_out=0, flag_invalid=0, sticky=0.
- op_a = an sNaN constant (bit1=0), op_b = a qNaN constant -> fp8_out = op_a|8'h02, is_nan_out=1, flag_invalid=1; sticky_invalid=1 the cycle after the handshake.
- op_a=8'h3C, op_b = a qNaN, inv_op=1 -> fp8_out = op_b, flag_invalid=1. Then op_a, op_b non-NaN with inv_op=1 -> fp8_out=8'h7F.
- Back-to-back stream of 4 inputs with out_ready held 0 for 3 cycles -> in_ready falls after 2 accepts, fp8_out stable during the stall, all 4 results delivered in order with no loss or duplication.
- Sticky set, then clr_sticky pulsed in the same cycle as a handshake with flag_invalid=1 -> sticky stays 1. Next clr_sticky with no handshake -> sticky 0.
- Reset asserted while both stages are full -> out_valid=0 immediately (async). After release, no stale output appears and in_ready=1.
